// File: rtl/draw_cmd_pkg.sv
// Shared definitions for the draw command front end and the drawing engines.
// Holds opcode encodings, default field widths, screen limits and the bit
// offsets of the fields inside the line and circle op words.
package draw_cmd_pkg;

  localparam int COORD_W = 10;
  localparam int COLOR_W = 12;
  localparam int H_RES   = 640;
  localparam int V_RES   = 480;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_LINE   = 4'd1;
  localparam logic [3:0] OP_CIRCLE = 4'd2;

  localparam int LINE_OP_W   = 4 * COORD_W + COLOR_W;
  localparam int CIRCLE_OP_W = 3 * COORD_W + COLOR_W;

  // Line op: {x0, y0, x1, y1, color}
  localparam int LINE_X0_LSB = 3 * COORD_W + COLOR_W;
  localparam int LINE_Y0_LSB = 2 * COORD_W + COLOR_W;
  localparam int LINE_X1_LSB = COORD_W + COLOR_W;
  localparam int LINE_Y1_LSB = COLOR_W;
  localparam int LINE_CL_LSB = 0;

  // Circle op: {xc, yc, r, color}
  localparam int CIRC_XC_LSB = 2 * COORD_W + COLOR_W;
  localparam int CIRC_YC_LSB = COORD_W + COLOR_W;
  localparam int CIRC_R_LSB  = COLOR_W;
  localparam int CIRC_CL_LSB = 0;

  typedef enum logic [1:0] {
    ST_HDR,
    ST_P1,
    ST_P2,
    ST_ISSUE
  } disp_state_t;

endpackage

// File: rtl/op_slot.sv
// One-entry rts/rtr holding register for a drawing-engine op.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load, load_data write a new op (caller only loads when free is high)
//   rtr             downstream ready
//   rts, op         registered op valid and op word
//   free            slot can accept a load this cycle (empty or unloading)
module op_slot #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         rtr,
  output logic         rts,
  output logic [W-1:0] op,
  output logic         free
);

  // An occupied slot that is unloading this cycle may be reloaded in the same cycle.
  assign free = ~rts | rtr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rts <= 1'b0;
      op  <= '0;
    end else if (load) begin
      rts <= 1'b1;
      op  <= load_data;
    end else if (rtr) begin
      rts <= 1'b0;
    end
  end

endmodule

// File: rtl/draw_cmd_dispatcher.sv
// Command-word front end for the line and circle drawing engines.
// Assembles 3-word packets (header, P1, P2) from a 32-bit rts/rtr stream,
// range-checks coordinates and hands each op to a one-entry output slot.
// Ports:
//   clk, rst_                 clock, asynchronous active-low reset
//   in_data, in_rts, in_rtr   command word stream
//   line_op/_rts/_rtr         line engine op interface
//   circle_op/_rts/_rtr       circle engine op interface
//   busy                      packet in assembly or an output slot occupied
//   err_count                 saturating count of dropped packets
module draw_cmd_dispatcher
  import draw_cmd_pkg::*;
#(
  parameter int COORD_W   = draw_cmd_pkg::COORD_W,
  parameter int COLOR_W   = draw_cmd_pkg::COLOR_W,
  parameter int H_RES     = draw_cmd_pkg::H_RES,
  parameter int V_RES     = draw_cmd_pkg::V_RES,
  parameter int ERR_CNT_W = 8
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic [31:0]                  in_data,
  input  logic                         in_rts,
  output logic                         in_rtr,
  output logic [4*COORD_W+COLOR_W-1:0] line_op,
  output logic                         line_rts,
  input  logic                         line_rtr,
  output logic [3*COORD_W+COLOR_W-1:0] circle_op,
  output logic                         circle_rts,
  input  logic                         circle_rtr,
  output logic                         busy,
  output logic [ERR_CNT_W-1:0]         err_count
);

  localparam logic [COORD_W-1:0] X_LIM = COORD_W'(H_RES);
  localparam logic [COORD_W-1:0] Y_LIM = COORD_W'(V_RES);

  disp_state_t state, state_n;

  logic [3:0]         hdr_op;
  logic [COLOR_W-1:0] color;
  logic [COORD_W-1:0] p1_a, p1_b, p2_a, p2_b;

  logic xfer, is_line, is_circle, in_range, pkt_ok;
  logic line_load, circle_load, line_free, circle_free, err_inc;

  // Only selected fields of the command word are meaningful.
  logic unused_in;
  assign unused_in = ^in_data;

  assign xfer      = in_rts & in_rtr;
  assign is_line   = (hdr_op == OP_LINE);
  assign is_circle = (hdr_op == OP_CIRCLE);
  // Radius is deliberately unchecked; only the centre must lie on screen.
  assign in_range  = (p1_a < X_LIM) && (p1_b < Y_LIM) &&
                     (is_circle || ((p2_a < X_LIM) && (p2_b < Y_LIM)));
  assign pkt_ok    = (is_line || is_circle) && in_range;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) state <= ST_HDR;
    else       state <= state_n;
  end

  always_comb begin
    state_n     = state;
    in_rtr      = (state != ST_ISSUE);
    line_load   = 1'b0;
    circle_load = 1'b0;
    err_inc     = 1'b0;
    case (state)
      ST_HDR:   if (xfer && (in_data[31:28] != OP_NOP)) state_n = ST_P1;
      ST_P1:    if (xfer) state_n = ST_P2;
      ST_P2:    if (xfer) state_n = ST_ISSUE;
      ST_ISSUE: begin
        if (!pkt_ok) begin
          err_inc = 1'b1;
          state_n = ST_HDR;
        end else if (is_line) begin
          if (line_free) begin
            line_load = 1'b1;
            state_n   = ST_HDR;
          end
        end else if (circle_free) begin
          circle_load = 1'b1;
          state_n     = ST_HDR;
        end
      end
      default:  state_n = ST_HDR;
    endcase
  end

  // Packet fields are only read in ISSUE, after all three words have landed.
  always_ff @(posedge clk) begin
    if (xfer && state == ST_HDR) begin
      hdr_op <= in_data[31:28];
      color  <= in_data[COLOR_W-1:0];
    end
    if (xfer && state == ST_P1) begin
      p1_a <= in_data[16 +: COORD_W];
      p1_b <= in_data[0 +: COORD_W];
    end
    if (xfer && state == ST_P2) begin
      p2_a <= in_data[16 +: COORD_W];
      p2_b <= in_data[0 +: COORD_W];
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_)                         err_count <= '0;
    else if (err_inc && !(&err_count)) err_count <= err_count + 1'b1;
  end

  op_slot #(.W(4*COORD_W+COLOR_W)) u_line_slot (
    .clk       (clk),
    .rst_n     (rst_),
    .load      (line_load),
    .load_data ({p1_a, p1_b, p2_a, p2_b, color}),
    .rtr       (line_rtr),
    .rts       (line_rts),
    .op        (line_op),
    .free      (line_free)
  );

  op_slot #(.W(3*COORD_W+COLOR_W)) u_circle_slot (
    .clk       (clk),
    .rst_n     (rst_),
    .load      (circle_load),
    .load_data ({p1_a, p1_b, p2_b, color}),
    .rtr       (circle_rtr),
    .rts       (circle_rts),
    .op        (circle_op),
    .free      (circle_free)
  );

  assign busy = (state != ST_HDR) | line_rts | circle_rts;

endmodule

// File: tb/tb_draw_cmd_dispatcher.sv
module tb_draw_cmd_dispatcher;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_rts = 1'b0;
  logic        in_rtr;
  logic [51:0] line_op;
  logic        line_rts;
  logic        line_rtr = 1'b0;
  logic [41:0] circle_op;
  logic        circle_rts;
  logic        circle_rtr = 1'b0;
  logic        busy;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  draw_cmd_dispatcher dut (
    .clk        (clk),
    .rst_       (rst_),
    .in_data    (in_data),
    .in_rts     (in_rts),
    .in_rtr     (in_rtr),
    .line_op    (line_op),
    .line_rts   (line_rts),
    .line_rtr   (line_rtr),
    .circle_op  (circle_op),
    .circle_rts (circle_rts),
    .circle_rtr (circle_rtr),
    .busy       (busy),
    .err_count  (err_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ = 1'b0;
    in_rts = 1'b0;
    in_data = '0;
    line_rtr = 1'b0;
    circle_rtr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_ = 1'b1;
  endtask

  // Presents a word, waits (bounded) for in_rtr, then lets it transfer.
  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    in_rts = 1'b1;
    in_data = w;
    while (!in_rtr && n < 50) begin
      step();
      n++;
    end
    checks++;
    if (in_rtr !== 1'b1) begin
      failures++;
      $display("FAIL send_word_timeout word=%h in_rtr=%b required=1", w, in_rtr);
    end
    step();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({line_rts, circle_rts, busy, in_rtr} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_ctrl {line_rts,circle_rts,busy,in_rtr}=%b required=0001",
               {line_rts, circle_rts, busy, in_rtr});
    end
    checks++;
    if (line_op !== 52'd0 || circle_op !== 42'd0) begin
      failures++;
      $display("FAIL reset_ops line_op=%h circle_op=%h required=0", line_op, circle_op);
    end
    checks++;
    if (err_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_err err_count=%0d required=0", err_count);
    end
  endtask

  task automatic test_line();
    logic [51:0] exp_op;
    exp_op = {10'd0, 10'd0, 10'd639, 10'd479, 12'hFFF};
    do_reset();
    line_rtr = 1'b1;
    send_word(32'h1000_0FFF);
    send_word(32'h0000_0000);
    send_word(32'h027F_01DF);
    in_rts = 1'b0;
    checks++;
    if (line_rts !== 1'b0) begin
      failures++;
      $display("FAIL line_cycle3 line_rts=%b required=0", line_rts);
    end
    step();
    checks++;
    if (line_rts !== 1'b1 || line_op !== exp_op) begin
      failures++;
      $display("FAIL line_cycle4 line_rts=%b line_op=%h required rts=1 op=%h", line_rts, line_op, exp_op);
    end
    checks++;
    if (err_count !== 8'd0) begin
      failures++;
      $display("FAIL line_err err_count=%0d required=0", err_count);
    end
    step();
    checks++;
    if (line_rts !== 1'b0) begin
      failures++;
      $display("FAIL line_drop line_rts=%b required=0", line_rts);
    end
  endtask

  task automatic test_circle_hold();
    logic [41:0] exp_op;
    exp_op = 42'b0100111111_0011011101_0010000000_111100000000;
    do_reset();
    circle_rtr = 1'b0;
    send_word(32'h2000_0F00);
    send_word(32'h013F_00DD);
    send_word(32'h0000_0080);
    in_rts = 1'b0;
    step();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (circle_rts !== 1'b1 || circle_op !== exp_op) begin
        failures++;
        $display("FAIL circle_hold cyc=%0d circle_rts=%b circle_op=%h required rts=1 op=%h",
                 i, circle_rts, circle_op, exp_op);
      end
      step();
    end
    circle_rtr = 1'b1;
    step();
    circle_rtr = 1'b0;
    checks++;
    if (circle_rts !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL circle_unload circle_rts=%b busy=%b required=0,0", circle_rts, busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [51:0] op_a, op_b;
    op_a = {10'd1, 10'd2, 10'd3, 10'd4, 12'h123};
    op_b = {10'd5, 10'd6, 10'd7, 10'd8, 12'h456};
    do_reset();
    line_rtr = 1'b0;
    send_word(32'h1000_0123);
    send_word(32'h0001_0002);
    send_word(32'h0003_0004);
    send_word(32'h1000_0456);
    send_word(32'h0005_0006);
    send_word(32'h0007_0008);
    in_rts = 1'b0;
    repeat (3) step();
    checks++;
    if (in_rtr !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stall in_rtr=%b busy=%b required=0,1", in_rtr, busy);
    end
    checks++;
    if (line_rts !== 1'b1 || line_op !== op_a) begin
      failures++;
      $display("FAIL b2b_first line_rts=%b line_op=%h required rts=1 op=%h", line_rts, line_op, op_a);
    end
    line_rtr = 1'b1;
    step();
    line_rtr = 1'b0;
    checks++;
    if (line_rts !== 1'b1 || line_op !== op_b) begin
      failures++;
      $display("FAIL b2b_swap line_rts=%b line_op=%h required rts=1 op=%h", line_rts, line_op, op_b);
    end
    checks++;
    if (in_rtr !== 1'b1) begin
      failures++;
      $display("FAIL b2b_release in_rtr=%b required=1", in_rtr);
    end
    line_rtr = 1'b1;
    step();
    line_rtr = 1'b0;
    checks++;
    if (line_rts !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain line_rts=%b busy=%b required=0,0", line_rts, busy);
    end
  endtask

  task automatic test_errors();
    do_reset();
    line_rtr = 1'b1;
    send_word(32'h1000_0000);
    send_word(32'h0000_0000);
    send_word(32'h0280_0000);
    in_rts = 1'b0;
    step();
    checks++;
    if (err_count !== 8'd1 || line_rts !== 1'b0) begin
      failures++;
      $display("FAIL err_range err_count=%0d line_rts=%b required=1,0", err_count, line_rts);
    end
    send_word(32'h7000_0000);
    send_word(32'h0000_0000);
    send_word(32'h0000_0000);
    in_rts = 1'b0;
    step();
    checks++;
    if (err_count !== 8'd2 || line_rts !== 1'b0 || circle_rts !== 1'b0) begin
      failures++;
      $display("FAIL err_opcode err_count=%0d line_rts=%b circle_rts=%b required=2,0,0",
               err_count, line_rts, circle_rts);
    end
    send_word(32'h0000_0000);
    in_rts = 1'b0;
    checks++;
    if (busy !== 1'b0 || in_rtr !== 1'b1 || err_count !== 8'd2) begin
      failures++;
      $display("FAIL err_nop busy=%b in_rtr=%b err_count=%0d required=0,1,2", busy, in_rtr, err_count);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [51:0] exp_op;
    exp_op = {10'd1, 10'd1, 10'd2, 10'd2, 12'h001};
    do_reset();
    send_word(32'h2000_0F00);
    send_word(32'h013F_00DD);
    send_word(32'h0000_0080);
    send_word(32'h1000_0AAA);
    send_word(32'h0010_0020);
    in_rts = 1'b0;
    checks++;
    if (circle_rts !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre circle_rts=%b busy=%b required=1,1", circle_rts, busy);
    end
    #2;
    rst_ = 1'b0;
    #1;
    checks++;
    if ({line_rts, circle_rts, busy} !== 3'b000 || line_op !== 52'd0 ||
        circle_op !== 42'd0 || err_count !== 8'd0) begin
      failures++;
      $display("FAIL rstmid_async line_rts=%b circle_rts=%b busy=%b line_op=%h circle_op=%h err=%0d required all 0",
               line_rts, circle_rts, busy, line_op, circle_op, err_count);
    end
    #1;
    rst_ = 1'b1;
    step();
    send_word(32'h0030_0040);
    send_word(32'h0050_0060);
    in_rts = 1'b0;
    repeat (4) step();
    checks++;
    if ({line_rts, circle_rts, busy} !== 3'b000) begin
      failures++;
      $display("FAIL rstmid_noop {line_rts,circle_rts,busy}=%b required=000", {line_rts, circle_rts, busy});
    end
    send_word(32'h1000_0001);
    send_word(32'h0001_0001);
    send_word(32'h0002_0002);
    in_rts = 1'b0;
    step();
    checks++;
    if (line_rts !== 1'b1 || line_op !== exp_op) begin
      failures++;
      $display("FAIL rstmid_fresh line_rts=%b line_op=%h required rts=1 op=%h", line_rts, line_op, exp_op);
    end
  endtask

  task automatic test_err_saturation();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      send_word(32'hF000_0000);
      send_word(32'h0000_0000);
      send_word(32'h0000_0000);
      in_rts = 1'b0;
      step();
      if (i == 253) begin
        checks++;
        if (err_count !== 8'd254) begin
          failures++;
          $display("FAIL sat_254 err_count=%0d required=254", err_count);
        end
      end
      if (i == 254) begin
        checks++;
        if (err_count !== 8'd255) begin
          failures++;
          $display("FAIL sat_255 err_count=%0d required=255", err_count);
        end
      end
    end
    checks++;
    if (err_count !== 8'd255 || busy !== 1'b0) begin
      failures++;
      $display("FAIL sat_final err_count=%0d busy=%b required=255,0", err_count, busy);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_circle_hold();
    test_back_to_back();
    test_errors();
    test_reset_mid_packet();
    test_err_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/draw_cmd_dispatcher.md
Name: draw_cmd_dispatcher

Overview:
Upstream front end for the drawing engines. It accepts a 32-bit command-word stream over an rts/rtr handshake and assembles 3-word packets into line ops (52 bit) and circle ops (42 bit). It range-checks coordinates and presents each op on a 1-entry output slot to line_drawing_engine or circle_drawing_engine (in_op/in_rts/in_rtr). It replaces the static test-op tie-offs in the integration top.

Parameters:
COORD_W, 10, coordinate/radius field width
COLOR_W, 12, colour field width (4:4:4)
H_RES, 640, x coordinates must be < H_RES
V_RES, 480, y coordinates must be < V_RES
ERR_CNT_W, 8, width of the saturating error counter

Ports:
clk  input  1  system clock (25 MHz domain)
rst_  input  1  asynchronous active-low reset
in_data  input  32  command word
in_rts  input  1  upstream has a valid word
in_rtr  output  1  dispatcher accepts a word this cycle
line_op  output  52  {x0,y0,x1,y1,color} to the line engine in_op
line_rts  output  1  line_op valid
line_rtr  input  1  line engine ready
circle_op  output  42  {xc,yc,r,color} to the circle engine in_op
circle_rts  output  1  circle_op valid
circle_rtr  input  1  circle engine ready
busy  output  1  packet in assembly or any output slot occupied
err_count  output  ERR_CNT_W  count of dropped packets, saturating

Behaviour:
- Clocking: one clock, clk. Reset rst_ is asynchronous, active-low.
- Transfers: an input word transfers when in_rts & in_rtr. An output op transfers when X_rts & X_rtr.
- Packet format:
  - Header word: [31:28] opcode (0=NOP, 1=LINE, 2=CIRCLE, others illegal), [11:0] color; other bits ignored.
  - Payload word: [25:16] field A, [9:0] field B.
  - LINE: P1 = {x0,y0}, P2 = {x1,y1}.
  - CIRCLE: P1 = {xc,yc}, P2 B = r (A ignored).
  - NOP is a single-word packet. Illegal opcodes consume 2 payload words, are dropped, and increment err_count.
- FSM states HDR, P1, P2, ISSUE. Reset state is HDR.
  - HDR -> P1 on a header transfer with opcode != 0. NOP stays in HDR.
  - P1 -> P2 on transfer. P2 -> ISSUE on transfer.
  - ISSUE: in_rtr = 0.
    - If the packet is illegal or out of range: increment err_count (saturate at all-ones) and go to HDR.
    - Otherwise wait until the target slot is free, load it, and go to HDR.
    - A slot counts as free if X_rts = 0, or if X_rts & X_rtr in the same cycle (unload and reload in one cycle).
  - in_rtr = 1 in HDR, P1 and P2.
- Range check: LINE requires x0,x1 < H_RES and y0,y1 < V_RES. CIRCLE requires xc < H_RES and yc < V_RES. Radius is unchecked, including r = 0.
- Output slots:
  - Registered. X_rts rises the cycle after the ISSUE load and holds, with X_op stable, until the X_rts & X_rtr transfer.
  - The two slots are independent, so a line and a circle may be pending simultaneously. A second op of the same type stalls in ISSUE.
- Op bit maps:
  - line_op[51:42]=x0, [41:32]=y0, [31:22]=x1, [21:12]=y1, [11:0]=color.
  - circle_op[41:32]=xc, [31:22]=yc, [21:12]=r, [11:0]=color.
- Latency and throughput: with in_rts held high, the header transfers in cycle 0 and line_rts/circle_rts is high in cycle 4. Peak rate is one op per 4 cycles.
- busy = (state != HDR) | line_rts | circle_rts.
- Reset values: state HDR, line_rts = 0, circle_rts = 0, line_op = 0, circle_op = 0, err_count = 0, busy = 0. in_rtr = 1 after reset is released.
- Reset mid-packet or with slots full: the partial packet and pending ops are discarded. No output is presented after reset until a new complete packet arrives.
- err_count saturates and never wraps.

Decomposition:
- Shared package draw_cmd_pkg:
  - opcode constants OP_NOP, OP_LINE, OP_CIRCLE
  - COORD_W, COLOR_W, H_RES, V_RES
  - op field offsets, shared with line_drawing_engine and circle_drawing_engine
- Sub-module op_slot, parameterised by width: a 1-entry rts/rtr holding register. Instantiated twice.

Test Plan:
1. LINE packet 0x1000_0FFF, 0x0000_0000, 0x027F_01DF with line_rtr = 1 -> line_op = {0,0,639,479,0xFFF}, line_rts high exactly in cycle 4; err_count = 0.
2. CIRCLE packet 0x2000_0F00, 0x013F_00DD, 0x0000_0080 with circle_rtr held 0 -> circle_op = 42'b0100111111_0011011101_0010000000_111100000000, held stable for 20 cycles. When circle_rtr = 1, one transfer occurs and circle_rts drops the next cycle.
3. Two back-to-back LINE packets with line_rtr = 0 -> second packet stalls in ISSUE with in_rtr = 0. Raising line_rtr for 1 cycle unloads op 1 and loads op 2 in the same cycle; line_rts stays high.
4. LINE with x1 = 640 (P2 = 0x0280_0000), then opcode 0x7 packet, then NOP 0x0000_0000 -> no line_rts, err_count = 2, NOP takes one cycle, busy returns to 0.
5. Assert rst_ low asynchronously after P1 of a LINE packet and while circle_rts = 1 -> all outputs zero immediately. After release, P2-like words are parsed as headers, and no op appears until a full packet is sent.
6. Send 300 illegal packets -> err_count stops at 255 and does not wrap.
